// File: rtl/id_stage_pipe.sv
// Registered lc3b decode stage: register file, operand muxing and ID/EX register with flow control.
// Optional ID_REG_BYPASS_EN forwards a same-cycle writeback to the operand reads instead of stalling.

package lc3b_types;

   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] amux_sel;
      logic       bmux_sel;
      logic [1:0] imm_sel;
      logic       src_mux;
      logic [2:0] aluop;
      logic       load_cc;
      logic       mem_read;
      logic       mem_write;
   } lc3b_control_word;

endpackage

module id_stage_pipe
   import lc3b_types::*;
#(
   parameter int WIDTH    = 16,
   parameter int NUM_REGS = 8,
   parameter int RIDX     = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  lc3b_control_word ctrl,
   input  logic [15:0]      inst,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] pc_off,
   input  logic             uses_a,
   input  logic             uses_b,
   input  logic             is_load,
   input  logic [RIDX-1:0]  dest,
   input  logic             flush,
   input  logic             reg_load,
   input  logic [RIDX-1:0]  reg_dest,
   input  logic [WIDTH-1:0] reg_data,
   output logic             out_valid,
   input  logic             out_ready,
   output lc3b_control_word ctrl_out,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] reg_b,
   output logic [RIDX-1:0]  dest_out,
   output logic             is_load_out
);

   logic [WIDTH-1:0] regs [NUM_REGS];
   logic [RIDX-1:0]  src_a;
   logic [RIDX-1:0]  src_b;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;
   logic             advance;
   logic             load_use;
   logic             wb_conflict;
   logic             hazard;
   logic             accept;
   logic             unused_opcode_bits;

   assign unused_opcode_bits = ^inst[15:12];

   assign src_a = RIDX'(inst[8:6]);
   assign src_b = ctrl.src_mux ? RIDX'(inst[11:9]) : RIDX'(inst[2:0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (reg_load) begin
         regs[reg_dest] <= reg_data;
      end
   end

   // A writeback either forwards into this cycle's reads or forces a one-cycle retry.
`ifdef ID_REG_BYPASS_EN
   always_comb begin
      rd_a = regs[src_a];
      rd_b = regs[src_b];
      if (reg_load && reg_dest == src_a) begin
         rd_a = reg_data;
      end
      if (reg_load && reg_dest == src_b) begin
         rd_b = reg_data;
      end
   end

   assign wb_conflict = 1'b0;
`else
   always_comb begin
      rd_a = regs[src_a];
      rd_b = regs[src_b];
   end

   assign wb_conflict = reg_load &
                        ((uses_a & (reg_dest == src_a)) | (uses_b & (reg_dest == src_b)));
`endif

   always_comb begin
      imm = '0;
      unique case (ctrl.imm_sel)
         2'd0:    imm = {{(WIDTH-5){inst[4]}}, inst[4:0]};
         2'd1:    imm = {{(WIDTH-7){inst[5]}}, inst[5:0], 1'b0};
         2'd2:    imm = {{(WIDTH-6){inst[5]}}, inst[5:0]};
         default: imm = {{(WIDTH-4){1'b0}}, inst[3:0]};
      endcase
   end

   always_comb begin
      a_next = rd_a;
      unique case (ctrl.amux_sel)
         2'd0:    a_next = rd_a;
         2'd1:    a_next = pc;
         2'd2:    a_next = pc_off;
         default: a_next = {{(WIDTH-9){1'b0}}, inst[7:0], 1'b0};
      endcase
      b_next = ctrl.bmux_sel ? imm : rd_b;
   end

   assign advance  = ~out_valid | out_ready;
   assign load_use = out_valid & is_load_out &
                     ((uses_a & (dest_out == src_a)) | (uses_b & (dest_out == src_b)));
   assign hazard   = load_use | wb_conflict;
   assign in_ready = advance & ~hazard & ~reset;
   assign accept   = in_valid & in_ready;

   // Flush outranks everything; a stalled EX keeps the captured operands frozen.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         out_valid   <= 1'b0;
         ctrl_out    <= '0;
         a           <= '0;
         b           <= '0;
         reg_b       <= '0;
         dest_out    <= '0;
         is_load_out <= 1'b0;
      end else if (advance) begin
         if (accept) begin
            out_valid   <= 1'b1;
            ctrl_out    <= ctrl;
            a           <= a_next;
            b           <= b_next;
            reg_b       <= rd_b;
            dest_out    <= dest;
            is_load_out <= is_load;
         end else begin
            out_valid   <= 1'b0;
            ctrl_out    <= '0;
            a           <= '0;
            b           <= '0;
            reg_b       <= '0;
            dest_out    <= '0;
            is_load_out <= 1'b0;
         end
      end
   end

endmodule
